// File: rtl/mux2_pair_pkg.sv
// Shared types and constants for the mux2 pair serializer.
package mux2_pair_pkg;

  typedef logic [1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT0 = 2'd1,
    BIT1 = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int GapCntWidth = 4;

endpackage

// File: rtl/pair_fifo.sv
// Circular-buffer FIFO of 2-bit words; head is presented combinationally on rdata_o.
module pair_fifo
  import mux2_pair_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  word_t                  wdata_i,
  input  logic                   pop_i,
  output word_t                  rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] fill_o
);

  localparam int AddrWidth = $clog2(Depth);
  localparam int FillWidth = AddrWidth + 1;

  word_t                 mem [Depth];
  logic [AddrWidth-1:0]  wr_ptr_reg;
  logic [AddrWidth-1:0]  rd_ptr_reg;
  logic [FillWidth-1:0]  fill_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (fill_reg == FillWidth'(Depth));
  assign empty_o = (fill_reg == '0);
  assign fill_o  = fill_reg;
  assign rdata_o = mem[rd_ptr_reg];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AddrWidth'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AddrWidth'(1);
      end
      case ({do_push, do_pop})
        2'b10:   fill_reg <= fill_reg + FillWidth'(1);
        2'b01:   fill_reg <= fill_reg - FillWidth'(1);
        default: fill_reg <= fill_reg;
      endcase
    end
  end

endmodule

// File: rtl/mux2_pair_serializer.sv
// Drives a 2:1 mux + AND merge cell so it emits bit 0 then bit 1 of each buffered word.
module mux2_pair_serializer
  import mux2_pair_pkg::*;
#(
  parameter int Depth     = 2,
  parameter int GapCycles = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [1:0]             i_o,
  output logic                   s_o,
  output logic                   b_o,
  output logic                   busy_o,
  output logic [$clog2(Depth):0] fill_o
);

  localparam logic [GapCntWidth-1:0] GapLoad = GapCntWidth'(GapCycles);

  state_e                 state_reg, state_next;
  word_t                  i_reg, i_next;
  logic                   s_reg, s_next;
  logic                   b_reg, b_next;
  logic                   busy_reg, busy_next;
  logic [GapCntWidth-1:0] cnt_reg, cnt_next;

  logic  push;
  logic  pop;
  logic  full;
  logic  empty;
  word_t head;

  assign ready_o = ~full;
  assign push    = valid_i & ready_o;

  pair_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .wdata_i(data_i),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty),
    .fill_o (fill_o)
  );

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    s_next     = 1'b0;
    b_next     = 1'b0;
    cnt_next   = cnt_reg;
    pop        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          i_next     = head;
          b_next     = 1'b1;
          state_next = BIT0;
        end
      end
      BIT0: begin
        s_next     = 1'b1;
        b_next     = 1'b1;
        state_next = BIT1;
      end
      BIT1: begin
        if (GapCycles > 0) begin
          cnt_next   = GapLoad;
          state_next = GAP;
        end else if (!empty) begin
          pop        = 1'b1;
          i_next     = head;
          b_next     = 1'b1;
          state_next = BIT0;
        end else begin
          state_next = IDLE;
        end
      end
      GAP: begin
        cnt_next = cnt_reg - GapCntWidth'(1);
        // Last gap cycle behaves like IDLE so a queued word starts without an extra bubble.
        if (cnt_reg <= GapCntWidth'(1)) begin
          if (!empty) begin
            pop        = 1'b1;
            i_next     = head;
            b_next     = 1'b1;
            state_next = BIT0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      s_reg     <= 1'b0;
      b_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      s_reg     <= s_next;
      b_reg     <= b_next;
      busy_reg  <= busy_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign i_o    = i_reg;
  assign s_o    = s_reg;
  assign b_o    = b_reg;
  assign busy_o = busy_reg;

endmodule

// File: tb/tb_mux2_pair_serializer.sv
// Directed vector bench: one DUT with default parameters, one with a two-cycle gap.
module tb_mux2_pair_serializer;

  typedef struct {
    logic       valid;
    logic [1:0] data;
    logic       ready;
    logic [1:0] fill;
    logic       busy;
    logic       b;
    logic       s;
    logic [1:0] i;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       valid_a, valid_b;
  logic [1:0] data_a, data_b;
  logic       ready_a, ready_b;
  logic [1:0] i_a, i_b;
  logic       s_a, s_b, b_a, b_b, busy_a, busy_b;
  logic [1:0] fill_a, fill_b;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t a_vec [23];
  vec_t b_vec [10];

  always #5 clk = ~clk;

  mux2_pair_serializer #(.Depth(2), .GapCycles(0)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .data_i (data_a),
    .valid_i(valid_a),
    .ready_o(ready_a),
    .i_o    (i_a),
    .s_o    (s_a),
    .b_o    (b_a),
    .busy_o (busy_a),
    .fill_o (fill_a)
  );

  mux2_pair_serializer #(.Depth(2), .GapCycles(2)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .data_i (data_b),
    .valid_i(valid_b),
    .ready_o(ready_b),
    .i_o    (i_b),
    .s_o    (s_b),
    .b_o    (b_b),
    .busy_o (busy_b),
    .fill_o (fill_b)
  );

  task automatic chk(input string name, input int row, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_all(input string tag, input int row, input vec_t v,
                           input logic rdy, input logic [1:0] fil, input logic bsy,
                           input logic bb, input logic ss, input logic [1:0] ii);
    $display("%s row %0d: valid=%b data=%b -> ready=%b fill=%0d busy=%b b=%b s=%b i=%b y=%b",
             tag, row, v.valid, v.data, rdy, fil, bsy, bb, ss, ii, bb & (ss ? ii[1] : ii[0]));
    chk({tag, ".ready"}, row, {1'b0, rdy}, {1'b0, v.ready});
    chk({tag, ".fill"},  row, fil,         v.fill);
    chk({tag, ".busy"},  row, {1'b0, bsy}, {1'b0, v.busy});
    chk({tag, ".b"},     row, {1'b0, bb},  {1'b0, v.b});
    chk({tag, ".s"},     row, {1'b0, ss},  {1'b0, v.s});
    chk({tag, ".i"},     row, ii,          v.i);
  endtask

  initial begin
    // valid, data | ready, fill, busy, b, s, i  (state after the edge)
    a_vec[0]  = '{1'b1, 2'b10, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00}; // single word
    a_vec[1]  = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'b10};
    a_vec[2]  = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 2'b10};
    a_vec[3]  = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'b10};
    a_vec[4]  = '{1'b1, 2'b01, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'b10}; // three back-to-back
    a_vec[5]  = '{1'b1, 2'b11, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'b01}; // push+pop at fill 1
    a_vec[6]  = '{1'b1, 2'b00, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 2'b01};
    a_vec[7]  = '{1'b0, 2'b00, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'b11};
    a_vec[8]  = '{1'b0, 2'b00, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 2'b11};
    a_vec[9]  = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'b00};
    a_vec[10] = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 2'b00};
    a_vec[11] = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00};
    a_vec[12] = '{1'b1, 2'b10, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00}; // fill to full
    a_vec[13] = '{1'b1, 2'b01, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'b10};
    a_vec[14] = '{1'b1, 2'b11, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 2'b10};
    a_vec[15] = '{1'b1, 2'b00, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'b01}; // rejected while full
    a_vec[16] = '{1'b0, 2'b00, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 2'b01};
    a_vec[17] = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'b11};
    a_vec[18] = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 2'b11};
    a_vec[19] = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'b11};
    a_vec[20] = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'b11};
    a_vec[21] = '{1'b1, 2'b10, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'b11}; // set up reset in BIT0
    a_vec[22] = '{1'b1, 2'b01, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'b10};

    b_vec[0]  = '{1'b1, 2'b01, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 2'b00};
    b_vec[1]  = '{1'b1, 2'b10, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 2'b01};
    b_vec[2]  = '{1'b0, 2'b00, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 2'b01};
    b_vec[3]  = '{1'b0, 2'b00, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 2'b01};
    b_vec[4]  = '{1'b0, 2'b00, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 2'b01};
    b_vec[5]  = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'b10};
    b_vec[6]  = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 2'b10};
    b_vec[7]  = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2'b10};
    b_vec[8]  = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 2'b10};
    b_vec[9]  = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'b10};

    rst_n   = 1'b0;
    valid_a = 1'b0;
    data_a  = 2'b00;
    valid_b = 1'b0;
    data_b  = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    begin
      vec_t r;
      r = '{1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00};
      check_all("reset_a", 0, r, ready_a, fill_a, busy_a, b_a, s_a, i_a);
    end
    rst_n = 1'b1;

    for (int k = 0; k < 23; k++) begin
      valid_a = a_vec[k].valid;
      data_a  = a_vec[k].data;
      @(posedge clk);
      #1;
      check_all("dut_a", k, a_vec[k], ready_a, fill_a, busy_a, b_a, s_a, i_a);
    end
    valid_a = 1'b0;

    // DUT A is in BIT0 with one word buffered: reset must clear without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    $display("async_reset: b=%b s=%b i=%b fill=%0d busy=%b ready=%b", b_a, s_a, i_a, fill_a, busy_a, ready_a);
    chk("async_reset.b",     0, {1'b0, b_a},     2'b00);
    chk("async_reset.i",     0, i_a,             2'b00);
    chk("async_reset.fill",  0, fill_a,          2'd0);
    chk("async_reset.busy",  0, {1'b0, busy_a},  2'b00);
    chk("async_reset.ready", 0, {1'b0, ready_a}, 2'b01);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      $display("post_reset row %0d: b=%b busy=%b fill=%0d i=%b", k, b_a, busy_a, fill_a, i_a);
      chk("post_reset.b",    k, {1'b0, b_a},    2'b00);
      chk("post_reset.busy", k, {1'b0, busy_a}, 2'b00);
      chk("post_reset.fill", k, fill_a,         2'd0);
      chk("post_reset.i",    k, i_a,            2'b00);
    end

    for (int k = 0; k < 10; k++) begin
      valid_b = b_vec[k].valid;
      data_b  = b_vec[k].data;
      @(posedge clk);
      #1;
      check_all("dut_b_gap2", k, b_vec[k], ready_b, fill_b, busy_b, b_b, s_b, i_b);
    end
    valid_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
